// File: rtl/ace_snoop_responder.sv
// Snoop-channel responder: accepts one AC snoop, looks the line up in the local cache,
// answers on CR, streams the line on CD when data transfer is needed, then commits the state change.
module ace_snoop_responder #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int LineBytes = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lookup_req_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_gnt_i,
    input  logic                 lookup_rvalid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    output logic                 data_req_o,
    output logic [AddrWidth-1:0] data_addr_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [DataWidth-1:0] data_rdata_i,
    output logic                 upd_valid_o,
    output logic                 upd_op_o,
    output logic [AddrWidth-1:0] upd_addr_o,
    input  logic                 upd_ready_i
);
    localparam int BytesPerBeat = DataWidth / 8;
    localparam int Beats        = LineBytes / BytesPerBeat;
    localparam int OffW         = $clog2(LineBytes);
    localparam int BeatW        = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int ReqW         = $clog2(Beats + 1);
    localparam logic [AddrWidth-1:0] LineMask  = {AddrWidth{1'b1}} << OffW;
    localparam logic [BeatW-1:0]     LastBeat  = BeatW'(Beats - 1);
    localparam logic [ReqW-1:0]      BeatsReq  = ReqW'(Beats);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_UPDATE} state_t;

    state_t               state_q, state_d;
    logic                 ac_ready_q, ac_ready_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic                 lookup_req_q, lookup_req_d;
    logic                 cr_valid_q, cr_valid_d;
    logic                 cr_done_q, cr_done_d;
    logic [4:0]           resp_q, resp_d;
    logic                 dt_q, dt_d;
    logic                 upd_en_q, upd_en_d;
    logic                 upd_op_q, upd_op_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [ReqW-1:0]      req_cnt_q, req_cnt_d;
    logic                 rd_out_q, rd_out_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [DataWidth-1:0] buf_data_q, buf_data_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic                 cd_done_q, cd_done_d;

    logic       dec_ok, dec_dt, dec_is, dec_pd, dec_upd, dec_op;
    logic [4:0] dec_resp;
    logic       dec_upd_en;

    always_comb begin
        dec_ok  = 1'b1;
        dec_dt  = 1'b0;
        dec_is  = 1'b0;
        dec_pd  = 1'b0;
        dec_upd = 1'b0;
        dec_op  = 1'b0;
        case (snoop_q)
            4'b0000: begin dec_dt = 1'b1; dec_is = 1'b1; end
            4'b0001, 4'b0010, 4'b0011: begin
                dec_dt = 1'b1; dec_is = 1'b1; dec_pd = lookup_dirty_i; dec_upd = 1'b1;
            end
            4'b0111: begin dec_dt = 1'b1; dec_pd = lookup_dirty_i; dec_upd = 1'b1; dec_op = 1'b1; end
            4'b1000: begin
                dec_dt = lookup_dirty_i; dec_pd = lookup_dirty_i; dec_is = 1'b1; dec_upd = lookup_dirty_i;
            end
            4'b1001: begin
                dec_dt = lookup_dirty_i; dec_pd = lookup_dirty_i; dec_upd = 1'b1; dec_op = 1'b1;
            end
            4'b1101: begin dec_upd = 1'b1; dec_op = 1'b1; end
            default: dec_ok = 1'b0;
        endcase
        // A miss or an unsupported snoop answers all-zero and leaves the line alone.
        dec_resp   = (lookup_hit_i && dec_ok) ?
                     {!lookup_shared_i, dec_is, dec_pd, 1'b0, dec_dt} : 5'b00000;
        dec_upd_en = lookup_hit_i && dec_ok && dec_upd;
    end

    logic cd_hs, cd_last, cr_hs, cr_ok, cd_ok;

    always_comb begin
        data_req_o = (state_q == S_RESP) && dt_q && !rd_out_q && !buf_valid_q && (req_cnt_q < BeatsReq);
        cd_hs      = buf_valid_q && cd_ready_i;
        cd_last    = buf_valid_q && (beat_q == LastBeat);
        cr_hs      = cr_valid_q && cr_ready_i;
        cr_ok      = cr_done_q || cr_hs;
        cd_ok      = !dt_q || cd_done_q || (cd_hs && cd_last);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        snoop_d      = snoop_q;
        lookup_req_d = lookup_req_q;
        cr_valid_d   = cr_valid_q;
        cr_done_d    = cr_done_q;
        resp_d       = resp_q;
        dt_d         = dt_q;
        upd_en_d     = upd_en_q;
        upd_op_d     = upd_op_q;
        upd_valid_d  = upd_valid_q;
        req_cnt_d    = req_cnt_q;
        rd_out_d     = rd_out_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        beat_d       = beat_q;
        cd_done_d    = cd_done_q;
        case (state_q)
            S_IDLE: begin
                if (ac_valid_i && ac_ready_q) begin
                    addr_d       = ac_addr_i & LineMask;
                    snoop_d      = ac_snoop_i;
                    lookup_req_d = 1'b1;
                    state_d      = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_gnt_i) begin
                    lookup_req_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lookup_rvalid_i) begin
                    resp_d     = dec_resp;
                    dt_d       = dec_resp[0];
                    upd_en_d   = dec_upd_en;
                    upd_op_d   = dec_op;
                    cr_valid_d = 1'b1;
                    cr_done_d  = 1'b0;
                    req_cnt_d  = '0;
                    beat_d     = '0;
                    cd_done_d  = 1'b0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (data_req_o && data_gnt_i) begin
                    rd_out_d  = 1'b1;
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (rd_out_q && data_rvalid_i) begin
                    rd_out_d    = 1'b0;
                    buf_valid_d = 1'b1;
                    buf_data_d  = data_rdata_i;
                end
                if (cd_hs) begin
                    buf_valid_d = 1'b0;
                    if (cd_last) cd_done_d = 1'b1;
                    else         beat_d    = beat_q + 1'b1;
                end
                if (cr_hs) begin
                    cr_valid_d = 1'b0;
                    cr_done_d  = 1'b1;
                end
                // The state update only follows the last data beat, so the line is read before it is dropped.
                if (cr_ok && cd_ok) begin
                    if (upd_en_q) begin
                        upd_valid_d = 1'b1;
                        state_d     = S_UPDATE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_UPDATE: begin
                if (upd_ready_i) begin
                    upd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ac_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ac_ready_q   <= 1'b0;
            addr_q       <= '0;
            snoop_q      <= '0;
            lookup_req_q <= 1'b0;
            cr_valid_q   <= 1'b0;
            cr_done_q    <= 1'b0;
            resp_q       <= '0;
            dt_q         <= 1'b0;
            upd_en_q     <= 1'b0;
            upd_op_q     <= 1'b0;
            upd_valid_q  <= 1'b0;
            req_cnt_q    <= '0;
            rd_out_q     <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            beat_q       <= '0;
            cd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ac_ready_q   <= ac_ready_d;
            addr_q       <= addr_d;
            snoop_q      <= snoop_d;
            lookup_req_q <= lookup_req_d;
            cr_valid_q   <= cr_valid_d;
            cr_done_q    <= cr_done_d;
            resp_q       <= resp_d;
            dt_q         <= dt_d;
            upd_en_q     <= upd_en_d;
            upd_op_q     <= upd_op_d;
            upd_valid_q  <= upd_valid_d;
            req_cnt_q    <= req_cnt_d;
            rd_out_q     <= rd_out_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            beat_q       <= beat_d;
            cd_done_q    <= cd_done_d;
        end
    end

    assign ac_ready_o    = ac_ready_q;
    assign cr_valid_o    = cr_valid_q;
    assign cr_resp_o     = resp_q;
    assign cd_valid_o    = buf_valid_q;
    assign cd_data_o     = buf_data_q;
    assign cd_last_o     = cd_last;
    assign lookup_req_o  = lookup_req_q;
    assign lookup_addr_o = addr_q;
    assign data_addr_o   = addr_q + AddrWidth'(req_cnt_q) * AddrWidth'(BytesPerBeat);
    assign upd_valid_o   = upd_valid_q;
    assign upd_op_o      = upd_op_q;
    assign upd_addr_o    = addr_q;

endmodule
